except_ctrl: RTL

//  Sequential exception/interrupt controller at the MEM stage of the MIPS pipeline.

---
 rtl/except_ctrl_if.sv | 44 ++++
 rtl/except_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/except_ctrl_if.sv
// Bundle between the MEM-stage pipeline/CP0 side (master) and the exception controller (slave).
// Flush handshake: flush is a one-cycle pulse carrying new_pc; the controller then holds busy
// until it samples flush_ack=1 (legal in the same cycle as flush), then returns to idle via CLEAR.
interface except_ctrl_if #(
    parameter int NUM_HW_INT = 6
);
    logic [NUM_HW_INT-1:0] hw_int;
    logic                  inst_valid;
    logic [7:0]            except;
    logic                  adel;
    logic                  ades;
    logic [31:0]           pc;
    logic [31:0]           data_addr;
    logic                  in_delay_slot;
    logic [31:0]           cp0_status;
    logic [1:0]            cp0_cause_sw;
    logic [31:0]           cp0_epc;
    logic                  flush_ack;

    logic [31:0]           excepttype;
    logic                  flush;
    logic [31:0]           new_pc;
    logic [31:0]           epc_out;
    logic [31:0]           badvaddr_out;
    logic                  badvaddr_we;
    logic                  bd_out;
    logic [NUM_HW_INT-1:0] ip_hw;
    logic                  busy;
    logic [1:0]            dbg_state;

    modport master (
        output hw_int, inst_valid, except, adel, ades, pc, data_addr, in_delay_slot,
               cp0_status, cp0_cause_sw, cp0_epc, flush_ack,
        input  excepttype, flush, new_pc, epc_out, badvaddr_out, badvaddr_we, bd_out,
               ip_hw, busy, dbg_state
    );

    modport slave (
        input  hw_int, inst_valid, except, adel, ades, pc, data_addr, in_delay_slot,
               cp0_status, cp0_cause_sw, cp0_epc, flush_ack,
        output excepttype, flush, new_pc, epc_out, badvaddr_out, badvaddr_we, bd_out,
               ip_hw, busy, dbg_state
    );
endinterface

// File: rtl/except_ctrl.sv
// MEM-stage exception/interrupt controller: synchronises hardware interrupts, prioritises
// them against the instruction's exception vector and drives a registered flush handshake.
module except_ctrl #(
    parameter int          NUM_HW_INT  = 6,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VEC     = 32'hBFC00380,
    parameter bit          ERET_VEC_EN = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    except_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t                state_q;
    logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
    logic [31:0]           excepttype_q;
    logic                  flush_q;
    logic [31:0]           new_pc_q;
    logic [31:0]           epc_q;
    logic [31:0]           badvaddr_q;
    logic                  badvaddr_we_q;
    logic                  bd_q;
    logic                  busy_q;

    logic [NUM_HW_INT+1:0] pend_vec;
    logic [NUM_HW_INT+1:0] im_vec;
    logic                  int_req;
    logic [31:0]           code_d;
    logic [31:0]           badvaddr_d;
    logic [31:0]           epc_d;
    logic [31:0]           new_pc_d;
    logic                  hit;
    logic                  unused_ok;

    // Level-sensitive: the last synchroniser stage is the pending latch itself.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.hw_int;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign pend_vec = {sync_q[SYNC_STAGES-1], bus.cp0_cause_sw};
    assign im_vec   = bus.cp0_status[8 +: NUM_HW_INT+2];
    assign int_req  = (|(pend_vec & im_vec)) & bus.cp0_status[0] & ~bus.cp0_status[1];

    always_comb begin
        code_d     = 32'h0;
        badvaddr_d = bus.data_addr;
        if (int_req)                                     code_d = 32'h1;
        else if (bus.except[7]) begin
            code_d     = 32'h4;
            badvaddr_d = bus.pc;
        end
        else if (bus.adel)                               code_d = 32'h4;
        else if (bus.ades)                               code_d = 32'h5;
        else if (bus.except[6])                          code_d = 32'h8;
        else if (bus.except[5])                          code_d = 32'h9;
        else if (bus.except[4] && ERET_VEC_EN)           code_d = 32'he;
        else if (bus.except[3])                          code_d = 32'ha;
        else if (bus.except[2])                          code_d = 32'hc;
    end

    assign hit      = bus.inst_valid && (code_d != 32'h0);
    assign epc_d    = bus.in_delay_slot ? bus.pc - 32'd4 : bus.pc;
    assign new_pc_d = (code_d == 32'he) ? bus.cp0_epc : EXC_VEC;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            excepttype_q  <= '0;
            flush_q       <= 1'b0;
            new_pc_q      <= '0;
            epc_q         <= '0;
            badvaddr_q    <= '0;
            badvaddr_we_q <= 1'b0;
            bd_q          <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        excepttype_q  <= code_d;
                        flush_q       <= 1'b1;
                        new_pc_q      <= new_pc_d;
                        epc_q         <= epc_d;
                        bd_q          <= bus.in_delay_slot;
                        badvaddr_q    <= badvaddr_d;
                        badvaddr_we_q <= (code_d == 32'h4) || (code_d == 32'h5);
                        busy_q        <= 1'b1;
                        state_q       <= S_WAIT;
                    end else begin
                        excepttype_q  <= '0;
                        flush_q       <= 1'b0;
                        badvaddr_we_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    flush_q       <= 1'b0;
                    badvaddr_we_q <= 1'b0;
                    if (bus.flush_ack) begin
                        busy_q  <= 1'b0;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    excepttype_q  <= '0;
                    badvaddr_we_q <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.excepttype   = excepttype_q;
    assign bus.flush        = flush_q;
    assign bus.new_pc       = new_pc_q;
    assign bus.epc_out      = epc_q;
    assign bus.badvaddr_out = badvaddr_q;
    assign bus.badvaddr_we  = badvaddr_we_q;
    assign bus.bd_out       = bd_q;
    assign bus.ip_hw        = sync_q[SYNC_STAGES-1];
    assign bus.busy         = busy_q;
    assign bus.dbg_state    = state_q;

    assign unused_ok = ^{bus.except[1:0], bus.cp0_status[7:2], bus.cp0_status[31:NUM_HW_INT+10]};

endmodule
